// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a small word-addressed register memory.
// Independent AW/W capture, byte strobes, fixed response latency, SLVERR outside the window.
module axi4_lite_slave_mem #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = 32'h0000_1020,
    parameter int unsigned             WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [7:0]                err_count
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_BITS   = $clog2(DEPTH);
    localparam int unsigned WIN_BYTES  = DEPTH * STRB_WIDTH;
    localparam int unsigned CNT_WIDTH  = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    // Offset arithmetic keeps the window check correct even when BASE+size wraps.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (offset < ADDR_WIDTH'(WIN_BYTES));
    endfunction

    function automatic logic [IDX_BITS-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = (addr - BASE_ADDR) >> OFF_BITS;
        return IDX_BITS'(offset);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  aw_held;
    logic                  w_held;
    logic                  ar_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_fire_c;
    logic                  r_fire_c;
    logic                  w_ok_c;
    logic                  r_ok_c;
    logic [1:0]            err_inc_c;
    logic [8:0]            err_sum_c;

    // Fire = the edge on which the response is produced (entering W_RESP / R_DATA).
    assign w_fire_c = ((w_state == W_IDLE) && aw_held && w_held && (WAIT_CYCLES == 0)) ||
                      ((w_state == W_WAIT) && (w_cnt == '0));
    assign r_fire_c = ((r_state == R_IDLE) && ar_held && (WAIT_CYCLES == 0)) ||
                      ((r_state == R_WAIT) && (r_cnt == '0));
    assign w_ok_c   = in_window(aw_addr_q);
    assign r_ok_c   = in_window(ar_addr_q);

    // Write channel: AW/W holding registers, wait counter, memory update and B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            w_cnt     <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VALUE;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_held && w_held) begin
                        if (WAIT_CYCLES == 0) begin
                            w_state <= W_RESP;
                        end else begin
                            w_state <= W_WAIT;
                            w_cnt   <= CNT_WIDTH'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        if (awvalid && awready) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= awaddr;
                            awready   <= 1'b0;
                        end else begin
                            awready   <= !aw_held;
                        end
                        if (wvalid && wready) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                            wready   <= 1'b0;
                        end else begin
                            wready   <= !w_held;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt != '0) begin
                        w_cnt <= w_cnt - CNT_WIDTH'(1);
                    end else begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        w_state <= W_IDLE;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase

            if (w_fire_c) begin
                bvalid <= 1'b1;
                bresp  <= w_ok_c ? RESP_OKAY : RESP_SLVERR;
                if (w_ok_c) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb_q[b]) begin
                            mem[word_index(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: captured AR address, wait counter, R response sampled from memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            ar_held   <= 1'b0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            r_cnt     <= '0;
            ar_addr_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_held) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= R_DATA;
                        end else begin
                            r_state <= R_WAIT;
                            r_cnt   <= CNT_WIDTH'(WAIT_CYCLES - 1);
                        end
                    end else if (arvalid && arready) begin
                        ar_held   <= 1'b1;
                        ar_addr_q <= araddr;
                        arready   <= 1'b0;
                    end else begin
                        arready   <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else begin
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                        ar_held <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            if (r_fire_c) begin
                rvalid <= 1'b1;
                rresp  <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
                rdata  <= r_ok_c ? mem[word_index(ar_addr_q)] : '0;
            end
        end
    end

    // Saturating SLVERR counter; both channels may report on the same edge.
    assign err_inc_c = 2'(w_fire_c && !w_ok_c) + 2'(r_fire_c && !r_ok_c);
    assign err_sum_c = 9'(err_count) + 9'(err_inc_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else begin
            err_count <= err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
        end
    end

endmodule

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

Parametrised, synthesizable AXI4-Lite slave backed by a word-addressed register memory. It is the standard target for AXI master and bridge benches, and a drop-in REG_TEST-style register window in the UART-AXI4 bridge. Improvements over a bare handshake model:
- independent AW/W acceptance
- byte strobes
- programmable response latency
- SLVERR decoding of out-of-window addresses
- an error counter

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; 32 or 64 only
- DEPTH, 4, number of DATA_WIDTH words; power of two, ≥2
- BASE_ADDR, 32'h0000_1020, byte address of word 0
- WAIT_CYCLES, 0, extra cycles inserted before bvalid/rvalid; 0–15
- RESET_VALUE, 0, reset contents of every word

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid/awready  in/out  1  write address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte-lane enables
- wvalid/wready  in/out  1  write data handshake
- bresp  out  2  write response
- bvalid/bready  out/in  1  write response handshake
- araddr  in  ADDR_WIDTH  read address
- arvalid/arready  in/out  1  read address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid/rready  out/in  1  read data handshake
- err_count  out  8  saturating count of SLVERR responses issued

## Operation
**Address decode.** Identical for AW and AR.
- Address is in range if BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*DATA_WIDTH/8.
- Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Out of range: response 2'b10 (SLVERR), no memory update, rdata = 0. In range: response 2'b00.

**Write FSM: W_IDLE → W_WAIT → W_RESP → W_IDLE.**
- AW and W are captured independently into one-entry holding registers.
- awready = 1 while AW is not held and the FSM is in W_IDLE. wready follows the same rule for W.
- AW and W may arrive in either order or on the same cycle. A held channel deasserts its ready until the B handshake completes.
- When both are held, the FSM leaves W_IDLE and counts WAIT_CYCLES in W_WAIT (skipped when 0).
- On the edge entering W_RESP:
  - memory bytes whose wstrb bit is 1 are written;
  - bvalid rises;
  - bresp is set.
- bvalid/bresp stay stable until bready. On the handshake edge the FSM returns to W_IDLE and both holding registers clear.

**Read FSM: R_IDLE → R_WAIT → R_DATA → R_IDLE.**
- arready = 1 only in R_IDLE. The AR handshake captures the address.
- R_WAIT counts WAIT_CYCLES (skipped when 0).
- On the edge entering R_DATA, rdata/rresp are sampled from memory and rvalid rises.
- rvalid/rdata/rresp stay stable until rready. The handshake edge returns the FSM to R_IDLE.

**err_count.** Increments once per SLVERR, on the edge bvalid or rvalid rises. If both rise on the same edge it increments by 2. It saturates at 255.

**Simultaneous read/write to the same word.** When the memory write and the read sample occur on the same edge, the read returns the old contents.

## Timing
**Reset** (while rst = 1, sampled at each edge):
- awready, wready, arready, bvalid, rvalid, err_count = 0
- bresp, rresp = 2'b00; rdata = 0
- every word = RESET_VALUE
- both FSMs return to idle

**Readys after reset.** awready, wready and arready are registered. They assert on the first edge with rst = 0, so they are high from cycle 1 after release.

**Write latency.** bvalid is high WAIT_CYCLES+1 cycles after the edge completing the later of the AW and W handshakes.

**Read latency.** rvalid is high WAIT_CYCLES+1 cycles after the AR handshake edge.

**Throughput.** With WAIT_CYCLES = 0 and bready/rready held high, one write and one read complete every 3 cycles per channel. The read and write channels run fully concurrently.

**Reset mid-transaction.** Any pending beat is discarded and no memory write occurs. bvalid/rvalid drop at the reset edge.

**No combinational paths.** All outputs are registered; there is no path from any input to any output.

## Test plan
- **Write/read basic.** Write 0x12345678 to 0x1020, wstrb = 4'hF, then read 0x1020.
  - Expect bresp = 00, rdata = 0x12345678, rresp = 00.
  - Expect bvalid 1 cycle and rvalid 1 cycle after the respective handshakes.
- **Byte strobes.** Write 0xDEADBEEF to 0x1024, then write 0x0000CAFE with wstrb = 4'b0011, then read 0x1024.
  - Expect rdata = 0xDEADCAFE.
- **Decode error.** Write to 0x1030, then read 0x101C.
  - Expect bresp = 10, rresp = 10, rdata = 0, err_count = 2.
  - Expect all words unchanged.
- **Channel ordering.** Present W 3 cycles before AW, with AW held pending.
  - Expect wready low after the W handshake and bvalid exactly 1 cycle after the AW handshake.
  - Repeat with AW first; expect the same result.
- **Backpressure and latency.** Set WAIT_CYCLES = 3 and hold bready/rready low for 5 cycles.
  - Expect bvalid/rvalid 4 cycles after the handshake, held stable with constant data.
  - Expect awready/wready/arready low throughout.
- **Reset mid-op.** Assert rst 1 cycle after a write's AW/W handshake, with WAIT_CYCLES = 3.
  - Expect no bvalid, all words = RESET_VALUE, and readys high from cycle 1 after release.
